ewa_tile_sched: RTL and testbench
=================================

// Module: ewa_tile_sched
// PURPOSE
//  Sequences the reconfigurable array through an element-wise (EWA/EWM) pass over D_INNER rows, one TILE_SIZE-row tile at a time.
//  Per tile it fetches operands, pulses the array's valid_in, waits for done_tile, then hands the tile result to writeback.
//  Sits between the SSM layer controller (start/done) and recfg_array plus its operand and result buffers.
// PARAMETERS
//  TILE_SIZE    16   rows per tile
//  D_INNER      256  total rows; max tiles = D_INNER/TILE_SIZE
//  TILE_CNT_W   5    width of tile count/index (holds 0..D_INNER/TILE_SIZE)
//  TIMEOUT_CYC  64   done_tile watchdog limit (used only with EWA_SCHED_TIMEOUT_EN)
// PORTS
//  clk              in   1           clock
//  rst_n            in   1           async active-low reset
//  start            in   1           launch pass; sampled only in IDLE
//  cfg_mode         in   3           3'b100 EWA-vec, 3'b101 EWA-mat, 3'b110 EWM-mat
//  cfg_num_tiles    in   TILE_CNT_W  tiles in this pass
//  busy             out  1           pass in progress
//  done             out  1           1-cycle pulse at end of pass
//  err_mode         out  1           1-cycle pulse: start with illegal cfg_mode
//  op_rd_en         out  1           1-cycle operand fetch request
//  op_rd_tile_idx   out  TILE_CNT_W  tile being fetched
//  op_rd_valid      in   1           operands for requested tile present on array inputs
//  arr_valid_in     out  1           1-cycle pulse to recfg_array valid_in
//  arr_mode         out  3           to recfg_array mode; latched at start
//  arr_accumulate_en out 1           tied 0 (EWA modes never accumulate)
//  arr_done_tile    in   1           recfg_array done_tile
//  wb_en            out  1           result writeback request, held until wb_ready
//  wb_tile_idx      out  TILE_CNT_W  tile being written back
//  wb_ready         in   1           writeback accepts (handshake when wb_en & wb_ready)
//  err_timeout      out  1           1-cycle pulse; only with EWA_SCHED_TIMEOUT_EN, else tied 0
// BEHAVIOUR
//  Reset: state IDLE; tile_idx=0; every output 0 (arr_mode=3'b000).
//  FSM: IDLE -> FETCH -> WAIT_OP -> ISSUE -> WAIT_DONE -> WRITE -> (FETCH | FIN) -> IDLE.
//  IDLE:
//   - start & legal mode & num_tiles>0: latch mode/num_tiles, tile_idx=0, go FETCH; busy=1 from the next cycle.
//   - start & illegal mode: err_mode pulse next cycle; stay IDLE; busy stays 0.
//   - start & num_tiles==0: go FIN; done pulses the cycle after start; no array activity.
//  FETCH: op_rd_en=1 for exactly one cycle; op_rd_tile_idx=tile_idx; go WAIT_OP.
//  WAIT_OP: wait op_rd_valid (may already be 1 on entry); go ISSUE.
//  ISSUE: arr_valid_in=1 for exactly one cycle; go WAIT_DONE.
//  WAIT_DONE: on arr_done_tile go WRITE. arr_done_tile in any other state is ignored.
//  WRITE:
//   - wb_en=1, wb_tile_idx=tile_idx, both held stable until wb_ready.
//   - On handshake: if tile_idx==num_tiles-1 go FIN, else tile_idx++ and go FETCH.
//  FIN: done=1 one cycle; busy drops with it; go IDLE.
//  Minimum 5 cycles per tile (FETCH..WRITE) when op_rd_valid, done_tile and wb_ready are immediate.
//  arr_mode constant while busy; start while busy is ignored (no error, no relatch).
//  Reset mid-pass: immediate return to IDLE; all pulses and requests deassert; no done.
//  tile_idx never wraps: the last tile is num_tiles-1.
//  num_tiles > D_INNER/TILE_SIZE is clamped to D_INNER/TILE_SIZE.
// CONFIGURATION
//  EWA_SCHED_TIMEOUT_EN defined:
//   - Counter runs in WAIT_DONE, cleared on ISSUE.
//   - Reaching TIMEOUT_CYC without arr_done_tile: err_timeout pulse, go IDLE, no done.
//  Undefined: no counter; WAIT_DONE waits indefinitely; err_timeout tied 0.
// STRUCTURE
//  Package ewa_sched_pkg:
//   - mode localparams MODE_EWA_VEC=3'b100, MODE_EWA_MAT=3'b101, MODE_EWM_MAT=3'b110.
//   - state enum typedef sched_state_t.
//   - legal-mode function is_ewa_mode().
//  Single module; watchdog kept inline under the macro, so no sub-module.
// TESTING
//  1. mode 100, num_tiles=16, done_tile 3 cycles after valid_in, wb_ready=1
//     -> 16 op_rd_en and 16 arr_valid_in pulses, wb_tile_idx 0..15 in order, one done 1 cycle after the idx-15 handshake.
//  2. start, cfg_mode=3'b011 -> err_mode pulse next cycle; busy, op_rd_en, arr_valid_in stay 0.
//  3. mode 101, num_tiles=0 -> done pulses 1 cycle after start; no op_rd_en, no arr_valid_in.
//  4. mode 110, num_tiles=2, wb_ready low 5 cycles on tile 0
//     -> wb_en and wb_tile_idx=0 held 6 cycles; no FETCH for tile 1 until the handshake.
//  5. EWA_SCHED_TIMEOUT_EN, TIMEOUT_CYC=64, no done_tile
//     -> err_timeout 64 cycles after arr_valid_in; busy=0; no done.
//  6. rst_n low during WAIT_DONE of tile 3 -> all outputs 0 at once; a new start runs cleanly from tile 0.

Source files
------------

// File: rtl/ewa_tile_sched_pkg.sv
// Shared types for the EWA/EWM tile scheduler: array mode codes, FSM states
// and the legal-mode check applied when a pass is launched.
package ewa_sched_pkg;

  localparam logic [2:0] MODE_EWA_VEC = 3'b100;
  localparam logic [2:0] MODE_EWA_MAT = 3'b101;
  localparam logic [2:0] MODE_EWM_MAT = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_OP,
    S_ISSUE,
    S_WAIT_DONE,
    S_WRITE,
    S_FIN
  } sched_state_t;

  function automatic logic is_ewa_mode(input logic [2:0] mode);
    return (mode == MODE_EWA_VEC) || (mode == MODE_EWA_MAT) || (mode == MODE_EWM_MAT);
  endfunction

endpackage

// File: rtl/ewa_tile_sched_if.sv
// Bundle of the scheduler's control, operand-fetch, array and writeback signals.
// master = scheduler side, slave = layer controller / array / buffer side.
interface ewa_tile_sched_if #(
  parameter int TILE_CNT_W = 5
);
  logic                  start;
  logic [2:0]            cfg_mode;
  logic [TILE_CNT_W-1:0] cfg_num_tiles;
  logic                  busy;
  logic                  done;
  logic                  err_mode;
  logic                  err_timeout;
  logic                  op_rd_en;
  logic [TILE_CNT_W-1:0] op_rd_tile_idx;
  logic                  op_rd_valid;
  logic                  arr_valid_in;
  logic [2:0]            arr_mode;
  logic                  arr_accumulate_en;
  logic                  arr_done_tile;
  logic                  wb_en;
  logic [TILE_CNT_W-1:0] wb_tile_idx;
  logic                  wb_ready;

  modport master (
    input  start, cfg_mode, cfg_num_tiles, op_rd_valid, arr_done_tile, wb_ready,
    output busy, done, err_mode, err_timeout, op_rd_en, op_rd_tile_idx,
           arr_valid_in, arr_mode, arr_accumulate_en, wb_en, wb_tile_idx
  );

  modport slave (
    output start, cfg_mode, cfg_num_tiles, op_rd_valid, arr_done_tile, wb_ready,
    input  busy, done, err_mode, err_timeout, op_rd_en, op_rd_tile_idx,
           arr_valid_in, arr_mode, arr_accumulate_en, wb_en, wb_tile_idx
  );
endinterface

// File: rtl/ewa_tile_sched.sv
// Steps recfg_array through an element-wise pass one tile at a time.
// Define EWA_SCHED_TIMEOUT_EN to add the done_tile watchdog (err_timeout).
module ewa_tile_sched
  import ewa_sched_pkg::*;
#(
  parameter int TILE_SIZE   = 16,
  parameter int D_INNER     = 256,
  parameter int TILE_CNT_W  = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input logic              clk,
  input logic              rst_n,
  ewa_tile_sched_if.master sif
);

  localparam logic [TILE_CNT_W-1:0] MAX_TILES = TILE_CNT_W'(D_INNER / TILE_SIZE);
  localparam logic [TILE_CNT_W-1:0] TILE_ONE  = TILE_CNT_W'(1);

  sched_state_t          state_reg, state_next;
  logic [TILE_CNT_W-1:0] tile_idx_reg, tile_idx_next;
  logic [TILE_CNT_W-1:0] num_tiles_reg, num_tiles_next;
  logic [2:0]            mode_reg, mode_next;
  logic                  err_mode_reg, err_mode_next;
  logic                  timeout_hit;

  logic                  op_rd_en_w;
  logic                  wb_en_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      tile_idx_reg  <= '0;
      num_tiles_reg <= '0;
      mode_reg      <= 3'b000;
      err_mode_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tile_idx_reg  <= tile_idx_next;
      num_tiles_reg <= num_tiles_next;
      mode_reg      <= mode_next;
      err_mode_reg  <= err_mode_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tile_idx_next  = tile_idx_reg;
    num_tiles_next = num_tiles_reg;
    mode_next      = mode_reg;
    err_mode_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (sif.start) begin
          if (!is_ewa_mode(sif.cfg_mode)) begin
            err_mode_next = 1'b1;
          end else if (sif.cfg_num_tiles == '0) begin
            mode_next  = sif.cfg_mode;
            state_next = S_FIN;
          end else begin
            mode_next      = sif.cfg_mode;
            num_tiles_next = (sif.cfg_num_tiles > MAX_TILES) ? MAX_TILES : sif.cfg_num_tiles;
            tile_idx_next  = '0;
            state_next     = S_FETCH;
          end
        end
      end
      S_FETCH:   state_next = S_WAIT_OP;
      S_WAIT_OP: if (sif.op_rd_valid) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // A done_tile arriving on the watchdog's last cycle still wins.
        if (sif.arr_done_tile) state_next = S_WRITE;
        else if (timeout_hit)  state_next = S_IDLE;
      end
      S_WRITE: begin
        if (sif.wb_ready) begin
          if (tile_idx_reg == num_tiles_reg - TILE_ONE) begin
            state_next = S_FIN;
          end else begin
            tile_idx_next = tile_idx_reg + TILE_ONE;
            state_next    = S_FETCH;
          end
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef EWA_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  // wd_cnt_reg holds cycles elapsed since arr_valid_in, so the pulse lands
  // exactly TIMEOUT_CYC cycles after the issue.
  logic [WD_W-1:0] wd_cnt_reg;
  logic            err_timeout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg      <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      err_timeout_reg <= timeout_hit;
      if (state_reg == S_ISSUE)          wd_cnt_reg <= WD_W'(1);
      else if (state_reg == S_WAIT_DONE) wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end

  assign timeout_hit     = (state_reg == S_WAIT_DONE) && !sif.arr_done_tile &&
                           (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));
  assign sif.err_timeout = err_timeout_reg;
`else
  assign timeout_hit     = 1'b0;
  assign sif.err_timeout = 1'b0;
`endif

  assign op_rd_en_w = (state_reg == S_FETCH);
  assign wb_en_w    = (state_reg == S_WRITE);

  assign sif.busy              = (state_reg != S_IDLE) && (state_reg != S_FIN);
  assign sif.done              = (state_reg == S_FIN);
  assign sif.err_mode          = err_mode_reg;
  assign sif.op_rd_en          = op_rd_en_w;
  assign sif.op_rd_tile_idx    = op_rd_en_w ? tile_idx_reg : '0;
  assign sif.arr_valid_in      = (state_reg == S_ISSUE);
  assign sif.arr_mode          = mode_reg;
  assign sif.arr_accumulate_en = 1'b0;
  assign sif.wb_en             = wb_en_w;
  assign sif.wb_tile_idx       = wb_en_w ? tile_idx_reg : '0;

endmodule

// File: tb/tb_ewa_tile_sched.sv
// Bench for ewa_tile_sched: each pass is planned as a cycle timeline from the
// handshake latencies, then replayed cycle by cycle against the DUT outputs.
module tb_ewa_tile_sched;

  localparam int TCW  = 5;
  localparam int MAXT = 16;
  localparam int TOC  = 64;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ewa_tile_sched_if #(.TILE_CNT_W(TCW)) sif ();

  ewa_tile_sched #(
    .TILE_SIZE(16), .D_INNER(256), .TILE_CNT_W(TCW), .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sif(sif)
  );

  // planned expectations and stimulus, indexed by cycle within a pass
  bit         e_busy[MAXC], e_done[MAXC], e_errm[MAXC], e_errt[MAXC];
  bit         e_op[MAXC], e_vin[MAXC], e_wb[MAXC];
  int         e_idx[MAXC];
  bit         d_start[MAXC], d_opv[MAXC], d_dt[MAXC], d_wbr[MAXC];
  logic [2:0] d_mode[MAXC];
  int         d_num[MAXC];
  int         len;
  logic [2:0] exp_mode;
  int         a_lat[32], d_lat[32], w_lat[32], iss_cyc[32];
  int         n_assert = 0;
  int         n_fail = 0;
  string      cur_tag;

  task automatic chk(input string what, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d %s: observed %0h expected %0h", cur_tag, c, what, obs, exp);
    end
  endtask

  task automatic set_lat(input int a, input int d, input int w);
    for (int t = 0; t < 32; t++) begin
      a_lat[t] = a; d_lat[t] = d; w_lat[t] = w;
    end
  endtask

  // Timeline of one pass: start in cycle 0, FETCH in cycle 1, each stage
  // advancing as soon as its handshake input is seen.
  task automatic build(input logic [2:0] mode, input int num, input bit noise, input bit hang0);
    int c, eff, iss, w0, last;
    for (int k = 0; k < MAXC; k++) begin
      e_busy[k] = 0; e_done[k] = 0; e_errm[k] = 0; e_errt[k] = 0;
      e_op[k] = 0; e_vin[k] = 0; e_wb[k] = 0; e_idx[k] = 0;
      d_start[k] = 0; d_opv[k] = 0; d_dt[k] = 0; d_wbr[k] = 0;
      d_mode[k] = 3'b000; d_num[k] = 0;
    end
    d_start[0] = 1; d_mode[0] = mode; d_num[0] = num;
    exp_mode = mode;
    if (mode != 3'b100 && mode != 3'b101 && mode != 3'b110) begin
      e_errm[1] = 1; len = 4;
      return;
    end
    eff = (num > MAXT) ? MAXT : num;
    if (eff == 0) begin
      e_done[1] = 1; len = 4;
      return;
    end
    c = 1;
    for (int t = 0; t < eff; t++) begin
      e_op[c] = 1; e_idx[c] = t;
      d_opv[c + 1 + a_lat[t]] = 1;
      if (noise) for (int k = c + 1; k <= c + a_lat[t]; k++) d_dt[k] = 1'($urandom_range(0, 1));
      iss = c + 2 + a_lat[t];
      iss_cyc[t] = iss;
      e_vin[iss] = 1;
      if (hang0 && t == 0) begin
        e_errt[iss + TOC] = 1;
        for (int k = 1; k < iss + TOC; k++) e_busy[k] = 1;
        len = iss + TOC + 3;
        return;
      end
      d_dt[iss + d_lat[t]] = 1;
      if (noise) for (int k = iss; k <= iss + d_lat[t]; k++) begin
        d_wbr[k] = 1'($urandom_range(0, 1));
        d_opv[k] = 1'($urandom_range(0, 1));
      end
      w0 = iss + d_lat[t] + 1;
      for (int k = w0; k <= w0 + w_lat[t]; k++) begin
        e_wb[k] = 1; e_idx[k] = t;
        if (noise) d_dt[k] = 1'($urandom_range(0, 1));
      end
      d_wbr[w0 + w_lat[t]] = 1;
      c = w0 + w_lat[t] + 1;
    end
    last = c;
    e_done[last] = 1;
    for (int k = 1; k < last; k++) begin
      e_busy[k] = 1;
      // start while busy must be ignored, whatever mode it carries
      if (noise && $urandom_range(0, 3) == 0) begin
        d_start[k] = 1; d_mode[k] = 3'($urandom_range(0, 7)); d_num[k] = $urandom_range(0, 31);
      end
    end
    len = last + 3;
  endtask

  task automatic run(input string tag, input int ncyc);
    int n_op, n_vin;
    cur_tag = tag; n_op = 0; n_vin = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      sif.start = d_start[c]; sif.cfg_mode = d_mode[c]; sif.cfg_num_tiles = TCW'(d_num[c]);
      sif.op_rd_valid = d_opv[c]; sif.arr_done_tile = d_dt[c]; sif.wb_ready = d_wbr[c];
      #1;
      chk("busy", c, sif.busy, e_busy[c]);
      chk("done", c, sif.done, e_done[c]);
      chk("err_mode", c, sif.err_mode, e_errm[c]);
      chk("err_timeout", c, sif.err_timeout, e_errt[c]);
      chk("op_rd_en", c, sif.op_rd_en, e_op[c]);
      chk("arr_valid_in", c, sif.arr_valid_in, e_vin[c]);
      chk("wb_en", c, sif.wb_en, e_wb[c]);
      chk("accumulate_en", c, sif.arr_accumulate_en, 0);
      if (e_op[c]) chk("op_rd_tile_idx", c, sif.op_rd_tile_idx, e_idx[c]);
      if (e_wb[c]) chk("wb_tile_idx", c, sif.wb_tile_idx, e_idx[c]);
      if (e_busy[c]) chk("arr_mode", c, sif.arr_mode, exp_mode);
      n_op += int'(sif.op_rd_en); n_vin += int'(sif.arr_valid_in);
    end
    $display("pass %-12s mode=%b tiles=%0d cycles=%0d op_rd_en=%0d valid_in=%0d",
             tag, d_mode[0], d_num[0], ncyc, n_op, n_vin);
  endtask

  task automatic drive_idle();
    sif.start = 0; sif.cfg_mode = 3'b000; sif.cfg_num_tiles = '0;
    sif.op_rd_valid = 0; sif.arr_done_tile = 0; sif.wb_ready = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    cur_tag = tag;
    chk("busy", 0, sif.busy, 0);
    chk("done", 0, sif.done, 0);
    chk("err_mode", 0, sif.err_mode, 0);
    chk("err_timeout", 0, sif.err_timeout, 0);
    chk("op_rd_en", 0, sif.op_rd_en, 0);
    chk("arr_valid_in", 0, sif.arr_valid_in, 0);
    chk("wb_en", 0, sif.wb_en, 0);
    chk("arr_mode", 0, sif.arr_mode, 0);
  endtask

  initial begin
    logic [2:0] m;
    int         n;
    drive_idle();

    // reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // full 16-tile EWA-vec pass, done_tile 3 cycles after valid_in
    set_lat(0, 3, 0);
    build(3'b100, 16, 0, 0); run("full16", len);

    // illegal mode
    build(3'b011, 4, 0, 0); run("bad_mode", len);

    // zero tiles
    build(3'b101, 0, 0, 0); run("zero_tiles", len);

    // writeback stall of 5 cycles on tile 0
    set_lat(0, 1, 0); w_lat[0] = 5;
    build(3'b110, 2, 0, 0); run("wb_stall", len);

    // oversize tile count is clamped
    set_lat(1, 2, 1);
    build(3'b101, 31, 0, 0); run("clamp", len);

`ifdef EWA_SCHED_TIMEOUT_EN
    set_lat(0, 1, 0);
    build(3'b100, 3, 0, 1); run("timeout", len);
`else
    set_lat(0, 100, 0);
    build(3'b100, 1, 0, 0); run("long_wait", len);
`endif

    // randomized passes with handshake latency and ignored-input noise
    for (int p = 0; p < 8; p++) begin
      m = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'(4 + $urandom_range(0, 2));
      n = $urandom_range(0, 31);
      for (int t = 0; t < 32; t++) begin
        a_lat[t] = $urandom_range(0, 3);
        d_lat[t] = $urandom_range(1, 4);
        w_lat[t] = $urandom_range(0, 3);
      end
      build(m, n, 1, 0); run($sformatf("rand%0d", p), len);
    end

    // reset during WAIT_DONE of tile 3, then a clean pass
    set_lat(0, 2, 0);
    build(3'b100, 5, 0, 0); run("pre_reset", iss_cyc[3] + 2);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset_mid");
    drive_idle();
    @(negedge clk);
    chk_all_zero("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_rel");
    set_lat(0, 1, 0);
    build(3'b101, 2, 0, 0); run("after_reset", len);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
